uart_tx_sched: RTL and testbench

- Bus-master sequencer that shares the UART peripheral's transmit path between NREQ byte-stream requesters.
- Programs the UART baud and control registers after reset and on request.
- Selects a requester round-robin, holds the grant for a whole packet, and for each byte polls the TX-busy status, then writes the data register.
- Sits between on-chip byte producers (console, debug, logger) and the UART register port.

---
 rtl/uart_pkg.sv | 39 +++
 rtl/rr_arbiter.sv | 35 +++
 rtl/uart_tx_sched.sv | 177 +++++++++++++++++
 tb/tb_uart_tx_sched.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// UART register map, control/status bit positions and scheduler state
// encoding shared by the UART transmit scheduler.
package uart_pkg;

   localparam logic [7:0] UART_CTRL   = 8'h00;
   localparam logic [7:0] UART_STATUS = 8'h04;
   localparam logic [7:0] UART_BAUD   = 8'h08;
   localparam logic [7:0] UART_TXDATA = 8'h0C;
   localparam logic [7:0] UART_RXDATA = 8'h10;

   localparam int CTRL_EN_BIT        = 0;
   localparam int CTRL_RX_EN_BIT     = 1;
   localparam int CTRL_ROM_BIT       = 2;
   localparam int STATUS_TX_BUSY_BIT = 0;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_CFG_BAUD = 3'd1,
      S_CFG_CTRL = 3'd2,
      S_POLL     = 3'd3,
      S_WRITE    = 3'd4,
      S_SETTLE   = 3'd5
   } sched_state_e;

   function automatic logic [31:0] reg_addr(input logic [7:0] offset);
      return {24'h0, offset};
   endfunction

   // The ROM-burst bit is held low so a config write never starts a burst.
   function automatic logic [31:0] ctrl_word(input logic rx_en);
      logic [31:0] w;
      w                 = '0;
      w[CTRL_EN_BIT]    = 1'b1;
      w[CTRL_RX_EN_BIT] = rx_en;
      w[CTRL_ROM_BIT]   = 1'b0;
      return w;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after
// the pointer, wrapping modulo NREQ; one-hot output, zero when idle.
module rr_arbiter #(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] ptr,
   output logic [NREQ-1:0]         gnt
);

   localparam int IDXW = $clog2(NREQ);

   logic            found;
   int              idx;
   logic [IDXW-1:0] sel;

   always_comb begin
      gnt   = '0;
      found = 1'b0;
      idx   = 0;
      sel   = '0;
      for (int i = 0; i < NREQ; i++) begin
         idx = int'(ptr) + i;
         if (idx >= NREQ) begin
            idx = idx - NREQ;
         end
         sel = idx[IDXW-1:0];
         if (!found && req[sel]) begin
            gnt[sel] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin UART transmit scheduler: programs baud/ctrl, then streams each
// granted packet into TXDATA one byte at a time, polling TX-busy first.
module uart_tx_sched
   import uart_pkg::*;
#(
   parameter int NREQ   = 4,
   parameter int SETTLE = 2
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              cfg_update_i,
   input  logic [31:0]       baud_i,
   input  logic              rx_en_i,
   input  logic [NREQ-1:0]   req_valid_i,
   input  logic [NREQ*8-1:0] req_data_i,
   input  logic [NREQ-1:0]   req_last_i,
   output logic [NREQ-1:0]   req_ready_o,
   output logic [NREQ-1:0]   grant_o,
   output logic              uart_req_o,
   output logic              uart_we_o,
   output logic [31:0]       uart_addr_o,
   output logic [31:0]       uart_data_o,
   input  logic [31:0]       uart_data_i,
   output logic              busy_o
);

   localparam int IDXW = $clog2(NREQ);
   localparam int CNTW = (SETTLE > 2) ? $clog2(SETTLE) : 1;
   localparam logic [IDXW-1:0] LAST_IDX    = IDXW'(NREQ - 1);
   localparam logic [CNTW-1:0] SETTLE_LOAD = CNTW'(SETTLE - 1);

   sched_state_e    state, state_nx;
   logic [IDXW-1:0] ptr, ptr_nx;
   logic [IDXW-1:0] owner, owner_nx;
   logic [IDXW-1:0] arb_idx;
   logic [NREQ-1:0] arb_gnt;
   logic [NREQ-1:0] grant_nx;
   logic [CNTW-1:0] cnt, cnt_nx;
   logic            locked, locked_nx;
   logic            cfg_pending, cfg_pending_nx;
   logic            owner_valid;
   logic            owner_last;
   logic [7:0]      owner_byte;
   logic            tx_busy;
   logic            unused_rd;

   rr_arbiter #(
      .NREQ(NREQ)
   ) u_arb (
      .req(req_valid_i),
      .ptr(ptr),
      .gnt(arb_gnt)
   );

   always_comb begin
      arb_idx = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (arb_gnt[k]) begin
            arb_idx = IDXW'(k);
         end
      end
   end

   assign owner_valid = req_valid_i[owner];
   assign owner_last  = req_last_i[owner];
   assign owner_byte  = req_data_i[{owner, 3'b000} +: 8];
   assign tx_busy     = uart_data_i[STATUS_TX_BUSY_BIT];
   assign unused_rd   = ^uart_data_i[31:1];
   assign busy_o      = (state != S_IDLE);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state       <= S_IDLE;
         ptr         <= '0;
         owner       <= '0;
         locked      <= 1'b0;
         grant_o     <= '0;
         cnt         <= '0;
         cfg_pending <= 1'b1;
      end else begin
         state       <= state_nx;
         ptr         <= ptr_nx;
         owner       <= owner_nx;
         locked      <= locked_nx;
         grant_o     <= grant_nx;
         cnt         <= cnt_nx;
         cfg_pending <= cfg_pending_nx;
      end
   end

   always_comb begin
      state_nx       = state;
      ptr_nx         = ptr;
      owner_nx       = owner;
      locked_nx      = locked;
      grant_nx       = grant_o;
      cnt_nx         = cnt;
      cfg_pending_nx = cfg_pending | cfg_update_i;
      uart_req_o     = 1'b0;
      uart_we_o      = 1'b0;
      uart_addr_o    = '0;
      uart_data_o    = '0;
      req_ready_o    = '0;

      case (state)
         S_IDLE: begin
            // Config only runs between packets; a locked owner keeps the bus.
            if (cfg_pending && !locked) begin
               state_nx = S_CFG_BAUD;
            end else if (locked) begin
               if (owner_valid) begin
                  state_nx = S_POLL;
               end
            end else if (|req_valid_i) begin
               owner_nx  = arb_idx;
               locked_nx = 1'b1;
               grant_nx  = arb_gnt;
               state_nx  = S_POLL;
            end
         end
         S_CFG_BAUD: begin
            uart_req_o  = 1'b1;
            uart_we_o   = 1'b1;
            uart_addr_o = reg_addr(UART_BAUD);
            uart_data_o = baud_i;
            state_nx    = S_CFG_CTRL;
         end
         S_CFG_CTRL: begin
            uart_req_o     = 1'b1;
            uart_we_o      = 1'b1;
            uart_addr_o    = reg_addr(UART_CTRL);
            uart_data_o    = ctrl_word(rx_en_i);
            cfg_pending_nx = cfg_update_i;
            state_nx       = S_IDLE;
         end
         S_POLL: begin
            uart_req_o  = 1'b1;
            uart_addr_o = reg_addr(UART_STATUS);
            if (!owner_valid) begin
               state_nx = S_IDLE;
            end else if (!tx_busy) begin
               state_nx = S_WRITE;
            end
         end
         S_WRITE: begin
            if (owner_valid) begin
               uart_req_o         = 1'b1;
               uart_we_o          = 1'b1;
               uart_addr_o        = reg_addr(UART_TXDATA);
               uart_data_o        = {24'h0, owner_byte};
               req_ready_o[owner] = 1'b1;
               if (owner_last) begin
                  locked_nx = 1'b0;
                  grant_nx  = '0;
                  ptr_nx    = (owner == LAST_IDX) ? '0 : owner + 1'b1;
               end
               cnt_nx   = SETTLE_LOAD;
               state_nx = S_SETTLE;
            end else begin
               state_nx = S_IDLE;
            end
         end
         S_SETTLE: begin
            // Give the UART time to raise busy before the next status poll.
            if (cnt == '0) begin
               state_nx = S_IDLE;
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: queued byte requesters, a UART status
// stub, and a per-cycle bus trace compared against hand-computed writes.
`timescale 1ns/1ps
module tb_uart_tx_sched;
   import uart_pkg::*;

   localparam int NREQ   = 4;
   localparam int SETTLE = 2;

   logic              clk = 1'b0;
   logic              rst_ni;
   logic              cfg_update_i;
   logic [31:0]       baud_i;
   logic              rx_en_i;
   logic [NREQ-1:0]   req_valid_i;
   logic [NREQ*8-1:0] req_data_i;
   logic [NREQ-1:0]   req_last_i;
   logic [NREQ-1:0]   req_ready_o;
   logic [NREQ-1:0]   grant_o;
   logic              uart_req_o;
   logic              uart_we_o;
   logic [31:0]       uart_addr_o;
   logic [31:0]       uart_data_o;
   logic [31:0]       uart_data_i;
   logic              busy_o;
   logic              stub_busy;

   always #5 clk = ~clk;
   assign uart_data_i = {31'h0, stub_busy};

   uart_tx_sched #(
      .NREQ(NREQ),
      .SETTLE(SETTLE)
   ) dut (
      .clk_i(clk),
      .rst_ni(rst_ni),
      .cfg_update_i(cfg_update_i),
      .baud_i(baud_i),
      .rx_en_i(rx_en_i),
      .req_valid_i(req_valid_i),
      .req_data_i(req_data_i),
      .req_last_i(req_last_i),
      .req_ready_o(req_ready_o),
      .grant_o(grant_o),
      .uart_req_o(uart_req_o),
      .uart_we_o(uart_we_o),
      .uart_addr_o(uart_addr_o),
      .uart_data_o(uart_data_o),
      .uart_data_i(uart_data_i),
      .busy_o(busy_o)
   );

   // Per-cycle bus trace sampled mid-cycle
   typedef struct packed {
      logic            busy;
      logic            req;
      logic            we;
      logic [7:0]      addr;
      logic [31:0]     data;
      logic            st;
      logic [NREQ-1:0] rdy;
      logic [NREQ-1:0] gnt;
   } trc_t;

   trc_t trace[$];
   trc_t t;

   always @(negedge clk) begin
      t.busy = busy_o;
      t.req  = uart_req_o;
      t.we   = uart_we_o;
      t.addr = uart_addr_o[7:0];
      t.data = uart_data_o;
      t.st   = uart_data_i[0];
      t.rdy  = req_ready_o;
      t.gnt  = grant_o;
      trace.push_back(t);
   end

   // Requester model: per-requester byte queues, popped on ready
   logic [7:0]      mem    [NREQ][16];
   logic            last_m [NREQ][16];
   int              len    [NREQ];
   int              head   [NREQ];
   logic [NREQ-1:0] rdy_s = '0;

   always @(negedge clk) rdy_s <= req_ready_o;

   always @(posedge clk) begin
      for (int k = 0; k < NREQ; k++) begin
         if (rdy_s[k]) head[k] <= head[k] + 1;
      end
   end

   always_comb begin
      req_valid_i = '0;
      req_data_i  = '0;
      req_last_i  = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (head[k] < len[k]) begin
            req_valid_i[k]      = 1'b1;
            req_data_i[8*k +: 8] = mem[k][head[k][3:0]];
            req_last_i[k]       = last_m[k][head[k][3:0]];
         end
      end
   end

   task automatic load(input int k, input logic [7:0] b, input logic l);
      mem[k][len[k][3:0]]    = b;
      last_m[k][len[k][3:0]] = l;
      len[k]                 = len[k] + 1;
   endtask

   function automatic bit all_consumed();
      for (int k = 0; k < NREQ; k++) begin
         if (head[k] != len[k]) return 1'b0;
      end
      return 1'b1;
   endfunction

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   logic [43:0] exp_w[$];

   task automatic expect_wr(input logic [7:0] a, input logic [31:0] d, input logic [NREQ-1:0] r);
      exp_w.push_back({a, d, r});
   endtask

   task automatic check_writes(input string tag, input int mark);
      logic [43:0] got[$];
      logic [43:0] g;
      int          stray;
      stray = 0;
      for (int i = mark; i < trace.size(); i++) begin
         if (trace[i].req && trace[i].we) got.push_back({trace[i].addr, trace[i].data, trace[i].rdy});
         else if (trace[i].rdy != '0) stray++;
      end
      check_val({tag, "_wr_count"}, 64'(got.size()), 64'(exp_w.size()));
      check_val({tag, "_stray_ready"}, 64'(stray), 64'd0);
      for (int i = 0; i < exp_w.size(); i++) begin
         g = (i < got.size()) ? got[i] : '1;
         check_val($sformatf("%s_wr%0d", tag, i), 64'(g), 64'(exp_w[i]));
      end
      exp_w.delete();
   endtask

   task automatic wait_done(input string tag, input int budget);
      bit done;
      done = 1'b0;
      repeat (3) @(negedge clk);
      for (int n = 0; n < budget && !done; n++) begin
         @(negedge clk);
         if (!busy_o && grant_o == '0 && all_consumed()) done = 1'b1;
      end
      check_val({tag, "_done"}, 64'(done), 64'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_wr(input string tag, input logic [7:0] b, input int budget);
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < budget && !seen; n++) begin
         @(negedge clk);
         if (uart_req_o && uart_we_o && uart_addr_o == 32'hC && uart_data_o[7:0] == b) seen = 1'b1;
      end
      check_val({tag, "_seen"}, 64'(seen), 64'd1);
   endtask

   task automatic count_polls(input int target, input int budget, output int cnt);
      cnt = 0;
      for (int n = 0; n < budget && cnt < target; n++) begin
         @(negedge clk);
         if (uart_req_o && !uart_we_o && uart_addr_o == 32'h4 && uart_data_i[0]) cnt++;
      end
   endtask

   initial begin
      int mark;
      int cnt;
      int w;
      int nb;
      int n0;
      int nr;
      bit found;

      rst_ni       = 1'b0;
      cfg_update_i = 1'b0;
      baud_i       = 32'h1B8;
      rx_en_i      = 1'b1;
      stub_busy    = 1'b0;
      #3;
      check_val("rst_uart_req", 64'(uart_req_o), 64'd0);
      check_val("rst_uart_we", 64'(uart_we_o), 64'd0);
      check_val("rst_uart_addr", 64'(uart_addr_o), 64'd0);
      check_val("rst_uart_data", 64'(uart_data_o), 64'd0);
      check_val("rst_ready", 64'(req_ready_o), 64'd0);
      check_val("rst_grant", 64'(grant_o), 64'd0);
      check_val("rst_busy", 64'(busy_o), 64'd0);

      // Configuration after reset
      @(negedge clk);
      @(negedge clk);
      mark   = trace.size();
      rst_ni = 1'b1;
      wait_done("cfg", 50);
      expect_wr(UART_BAUD, 32'h1B8, 4'b0000);
      expect_wr(UART_CTRL, 32'h3, 4'b0000);
      check_writes("cfg", mark);
      check_val("cfg_grant", 64'(grant_o), 64'd0);
      check_val("cfg_busy", 64'(busy_o), 64'd0);

      // Requesters 0 and 2, two-byte packets, all valid together
      mark = trace.size();
      load(0, 8'hA0, 1'b0);
      load(0, 8'hA1, 1'b1);
      load(2, 8'hC0, 1'b0);
      load(2, 8'hC1, 1'b1);
      wait_done("pkt02", 100);
      expect_wr(UART_TXDATA, 32'hA0, 4'b0001);
      expect_wr(UART_TXDATA, 32'hA1, 4'b0001);
      expect_wr(UART_TXDATA, 32'hC0, 4'b0100);
      expect_wr(UART_TXDATA, 32'hC1, 4'b0100);
      check_writes("pkt02", mark);

      // Pointer now 3: requester 3 beats requester 2
      mark = trace.size();
      load(2, 8'hD2, 1'b1);
      load(3, 8'hD3, 1'b1);
      wait_done("ptr3", 100);
      expect_wr(UART_TXDATA, 32'hD3, 4'b1000);
      expect_wr(UART_TXDATA, 32'hD2, 4'b0100);
      check_writes("ptr3", mark);

      // Requester 1 single byte: poll, write, two settle cycles
      mark = trace.size();
      load(1, 8'h41, 1'b1);
      wait_done("req1", 50);
      expect_wr(UART_TXDATA, 32'h41, 4'b0010);
      check_writes("req1", mark);
      found = 1'b0;
      w     = mark + 1;
      nr    = 0;
      for (int i = mark; i < trace.size(); i++) begin
         if (trace[i].req && !trace[i].we) nr++;
         if (!found && trace[i].req && trace[i].we) begin
            found = 1'b1;
            w     = i;
         end
      end
      if (w < 1) w = 1;
      check_val("req1_found", 64'(found), 64'd1);
      check_val("req1_poll_count", 64'(nr), 64'd1);
      check_val("req1_poll_before_wr", 64'({trace[w-1].req, trace[w-1].we, trace[w-1].addr}), 64'({1'b1, 1'b0, UART_STATUS}));
      check_val("req1_grant_at_wr", 64'(trace[w].gnt), 64'b0010);
      check_val("req1_settle", 64'({trace[w+1].busy, trace[w+1].req, trace[w+2].busy, trace[w+2].req, trace[w+3].busy}), 64'b10100);
      check_val("req1_grant_cleared", 64'(trace[w+1].gnt), 64'd0);
      check_val("req1_grant_end", 64'(grant_o), 64'd0);

      // TX-busy held for 20 polls
      stub_busy = 1'b1;
      mark      = trace.size();
      load(0, 8'h55, 1'b1);
      count_polls(20, 200, cnt);
      check_val("busy_polls_seen", 64'(cnt), 64'd20);
      @(posedge clk);
      #1;
      stub_busy = 1'b0;
      wait_done("busy", 50);
      expect_wr(UART_TXDATA, 32'h55, 4'b0001);
      check_writes("busy", mark);
      nb = 0;
      n0 = 0;
      w  = mark + 1;
      found = 1'b0;
      for (int i = mark; i < trace.size(); i++) begin
         if (trace[i].req && !trace[i].we && trace[i].st) nb++;
         if (trace[i].req && !trace[i].we && !trace[i].st) n0++;
         if (!found && trace[i].req && trace[i].we) begin
            found = 1'b1;
            w     = i;
         end
      end
      if (w < 1) w = 1;
      check_val("busy_poll_hi", 64'(nb), 64'd20);
      check_val("busy_poll_lo", 64'(n0), 64'd1);
      check_val("busy_wr_after_free", 64'({trace[w-1].req, trace[w-1].we, trace[w-1].st}), 64'b100);

      // Config update during the first byte of a 3-byte packet
      baud_i  = 32'h2A;
      rx_en_i = 1'b0;
      mark    = trace.size();
      load(1, 8'h10, 1'b0);
      load(1, 8'h11, 1'b0);
      load(1, 8'h12, 1'b1);
      load(3, 8'h33, 1'b1);
      wait_wr("upd_first", 8'h10, 50);
      cfg_update_i = 1'b1;
      @(negedge clk);
      cfg_update_i = 1'b0;
      wait_done("upd", 100);
      expect_wr(UART_TXDATA, 32'h10, 4'b0010);
      expect_wr(UART_TXDATA, 32'h11, 4'b0010);
      expect_wr(UART_TXDATA, 32'h12, 4'b0010);
      expect_wr(UART_BAUD, 32'h2A, 4'b0000);
      expect_wr(UART_CTRL, 32'h1, 4'b0000);
      expect_wr(UART_TXDATA, 32'h33, 4'b1000);
      check_writes("upd", mark);

      // Config update in the same cycle as a last-byte write
      baud_i  = 32'h1B8;
      rx_en_i = 1'b1;
      mark    = trace.size();
      load(0, 8'h70, 1'b1);
      load(2, 8'h72, 1'b1);
      wait_wr("upd_last", 8'h70, 50);
      cfg_update_i = 1'b1;
      @(negedge clk);
      cfg_update_i = 1'b0;
      wait_done("updl", 100);
      expect_wr(UART_TXDATA, 32'h70, 4'b0001);
      expect_wr(UART_BAUD, 32'h1B8, 4'b0000);
      expect_wr(UART_CTRL, 32'h3, 4'b0000);
      expect_wr(UART_TXDATA, 32'h72, 4'b0100);
      check_writes("updl", mark);

      // Reset while polling with a lock held (pointer is 3 beforehand)
      stub_busy = 1'b1;
      load(1, 8'h5A, 1'b1);
      count_polls(3, 50, cnt);
      check_val("rst_polls_seen", 64'(cnt), 64'd3);
      check_val("rst_lock_grant", 64'(grant_o), 64'b0010);
      rst_ni = 1'b0;
      #1;
      check_val("mid_rst_uart_req", 64'(uart_req_o), 64'd0);
      check_val("mid_rst_uart_addr", 64'(uart_addr_o), 64'd0);
      check_val("mid_rst_uart_data", 64'(uart_data_o), 64'd0);
      check_val("mid_rst_grant", 64'(grant_o), 64'd0);
      check_val("mid_rst_ready", 64'(req_ready_o), 64'd0);
      check_val("mid_rst_busy", 64'(busy_o), 64'd0);
      load(3, 8'h3C, 1'b1);
      stub_busy = 1'b0;
      @(negedge clk);
      mark   = trace.size();
      rst_ni = 1'b1;
      wait_done("rst", 100);
      expect_wr(UART_BAUD, 32'h1B8, 4'b0000);
      expect_wr(UART_CTRL, 32'h3, 4'b0000);
      expect_wr(UART_TXDATA, 32'h5A, 4'b0010);
      expect_wr(UART_TXDATA, 32'h3C, 4'b1000);
      check_writes("rst", mark);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
